// File: rtl/acp_write_packer_pkg.sv
// Shared parameters and helpers for the ACP write packer and its output buffer.
package acp_write_packer_pkg;
  localparam int ACP_WIDTH     = 64;
  localparam int WORD_WIDTH    = 32;
  localparam int BATCH_WORDS   = 512;
  localparam int OUT_DEPTH     = 16;
  localparam int CNT_W         = 5;
  localparam int LANES         = ACP_WIDTH / WORD_WIDTH;
  localparam int FIFO_DEPTH    = 512;
  localparam int AXI_BURST_LEN = 16;

  // Counter/pointer width that stays legal when the range collapses to one value.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/acp_write_packer_if.sv
// Result-word input, flush and packed-beat output signals of the ACP write packer.
interface acp_write_packer_if #(
  parameter int ACP_WIDTH  = acp_write_packer_pkg::ACP_WIDTH,
  parameter int WORD_WIDTH = acp_write_packer_pkg::WORD_WIDTH,
  parameter int CNT_W      = acp_write_packer_pkg::CNT_W
);
  logic [WORD_WIDTH-1:0] in_data;
  logic                  in_empty_n;
  logic                  in_deq;
  logic                  flush;
  logic [ACP_WIDTH-1:0]  out_data;
  logic                  out_valid;
  logic [CNT_W-1:0]      out_count;
  logic                  out_deq;
  logic                  batch_done;

  modport master (
    output in_data, in_empty_n, flush, out_deq,
    input  in_deq, out_data, out_valid, out_count, batch_done
  );

  modport slave (
    input  in_data, in_empty_n, flush, out_deq,
    output in_deq, out_data, out_valid, out_count, batch_done
  );
endinterface

// File: rtl/acp_write_packer_reg_fifo.sv
// Register FIFO with occupancy count, registered FWFT head and same-cycle push/pop.
module acp_write_packer_reg_fifo
  import acp_write_packer_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A pop frees the slot the push needs, so push at full is legal alongside a pop.
  assign do_pop  = pop & (count_q != '0);
  assign do_push = push & ((count_q != CNT_W'(DEPTH)) | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign valid = (count_q != '0);
  assign count = count_q;
  assign head  = valid ? mem_q[rd_ptr_q] : '0;
endmodule

// File: rtl/acp_write_packer.sv
// Packs result words LSB-first into ACP beats, pads partial beats at batch end or flush,
// and queues finished beats in a register FIFO for the ACP write FSM.
module acp_write_packer
#(
  parameter int ACP_WIDTH   = acp_write_packer_pkg::ACP_WIDTH,
  parameter int WORD_WIDTH  = acp_write_packer_pkg::WORD_WIDTH,
  parameter int BATCH_WORDS = acp_write_packer_pkg::BATCH_WORDS,
  parameter int OUT_DEPTH   = acp_write_packer_pkg::OUT_DEPTH,
  parameter int CNT_W       = acp_write_packer_pkg::CNT_W
) (
  input  logic               CLK,
  input  logic               RST_N,
  acp_write_packer_if.slave  bus
);
  import acp_write_packer_pkg::*;

  localparam int LANES  = ACP_WIDTH / WORD_WIDTH;
  localparam int LANE_W = $clog2(LANES + 1);
  localparam int WORD_W = cnt_width(BATCH_WORDS);

  logic [ACP_WIDTH-1:0] pack_reg_q, pack_reg_d;
  logic [LANE_W-1:0]    lane_cnt_q, lane_cnt_d;
  logic [WORD_W-1:0]    word_cnt_q, word_cnt_d;
  logic                 pack_full_q, pack_full_d;
  logic                 last_q, last_d;
  logic                 accept, push, buf_full, last_word;

  assign buf_full  = (bus.out_count == CNT_W'(OUT_DEPTH));
  assign accept    = bus.in_empty_n & ~pack_full_q & RST_N;
  assign push      = pack_full_q & (~buf_full | bus.out_deq);
  assign last_word = (word_cnt_q == WORD_W'(BATCH_WORDS - 1));

  assign bus.in_deq     = accept;
  assign bus.batch_done = push & last_q;

  always_comb begin
    pack_reg_d  = pack_reg_q;
    lane_cnt_d  = lane_cnt_q;
    word_cnt_d  = word_cnt_q;
    pack_full_d = pack_full_q;
    last_d      = last_q;
    if (push) begin
      pack_reg_d  = '0;
      lane_cnt_d  = '0;
      pack_full_d = 1'b0;
      last_d      = 1'b0;
    end else begin
      if (accept) begin
        for (int k = 0; k < LANES; k++)
          if (lane_cnt_q == LANE_W'(k)) pack_reg_d[k*WORD_WIDTH +: WORD_WIDTH] = bus.in_data;
        lane_cnt_d = lane_cnt_q + 1'b1;
        word_cnt_d = last_word ? '0 : word_cnt_q + 1'b1;
        if (last_word || (lane_cnt_q == LANE_W'(LANES - 1))) pack_full_d = 1'b1;
        last_d = last_word;
      end
      // A word accepted alongside flush joins the beat before it closes.
      if (bus.flush && (lane_cnt_d != '0)) pack_full_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pack_reg_q  <= '0;
      lane_cnt_q  <= '0;
      word_cnt_q  <= '0;
      pack_full_q <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      pack_reg_q  <= pack_reg_d;
      lane_cnt_q  <= lane_cnt_d;
      word_cnt_q  <= word_cnt_d;
      pack_full_q <= pack_full_d;
      last_q      <= last_d;
    end
  end

  acp_write_packer_reg_fifo #(
    .WIDTH (ACP_WIDTH),
    .DEPTH (OUT_DEPTH),
    .CNT_W (CNT_W)
  ) u_out_buf (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .push      (push),
    .push_data (pack_reg_q),
    .pop       (bus.out_deq),
    .head      (bus.out_data),
    .valid     (bus.out_valid),
    .count     (bus.out_count)
  );
endmodule

// File: tb/tb_acp_write_packer.sv
// Randomised and directed bench for acp_write_packer against a queue-based beat model.
module tb_acp_write_packer;
  localparam int AW = 64;
  localparam int WW = 32;
  localparam int BW = 9;
  localparam int OD = 2;
  localparam int CW = 2;
  localparam int LN = AW / WW;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  acp_write_packer_if #(.ACP_WIDTH(AW), .WORD_WIDTH(WW), .CNT_W(CW)) bus ();

  acp_write_packer #(
    .ACP_WIDTH(AW), .WORD_WIDTH(WW), .BATCH_WORDS(BW), .OUT_DEPTH(OD), .CNT_W(CW)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  int vectors;
  int miscompares;

  logic [WW-1:0] src[$];
  logic [AW-1:0] m_out[$];
  logic [WW-1:0] m_cur[$];
  bit            m_closed, m_last;
  int            m_wib;

  logic [AW+CW+2:0] obs_vec, exp_vec;
  logic             obs_in_deq, obs_valid, obs_bd;
  logic [CW-1:0]    obs_count;
  logic [AW-1:0]    obs_data;

  task automatic model_clear();
    src.delete();
    m_out.delete();
    m_cur.delete();
    m_closed = 0;
    m_last   = 0;
    m_wib    = 0;
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    bus.in_empty_n = 1'b0;
    bus.in_data = '0;
    bus.flush = 1'b0;
    bus.out_deq = 1'b0;
    model_clear();
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  // One clock: drive inputs, sample outputs before the edge, then advance the model.
  task automatic drive(input bit ien, input bit fl, input bit dq);
    bit            avail, e_deq, e_push;
    logic [AW-1:0] head, beat;
    @(negedge CLK);
    avail = ien && (src.size() > 0);
    bus.in_empty_n = avail;
    bus.in_data = (src.size() > 0) ? src[0] : '0;
    bus.flush = fl;
    bus.out_deq = dq;
    #1;
    obs_in_deq = bus.in_deq;
    obs_valid  = bus.out_valid;
    obs_count  = bus.out_count;
    obs_data   = bus.out_data;
    obs_bd     = bus.batch_done;
    obs_vec    = {obs_in_deq, obs_valid, obs_count, obs_data, obs_bd};
    e_deq  = avail && !m_closed;
    e_push = m_closed && ((m_out.size() < OD) || dq);
    head   = '0;
    if (m_out.size() > 0) head = m_out[0];
    exp_vec = {e_deq, (m_out.size() > 0), CW'(m_out.size()), head, (e_push && m_last)};
    @(posedge CLK);
    if (dq && (m_out.size() > 0)) void'(m_out.pop_front());
    if (e_push) begin
      beat = '0;
      for (int i = 0; i < m_cur.size(); i++) beat[i*WW +: WW] = m_cur[i];
      m_out.push_back(beat);
      m_cur.delete();
      m_closed = 0;
      m_last   = 0;
    end else begin
      if (e_deq) begin
        m_cur.push_back(src[0]);
        m_wib++;
        if (m_wib == BW) begin
          m_closed = 1;
          m_last   = 1;
          m_wib    = 0;
        end else if (m_cur.size() == LN) begin
          m_closed = 1;
        end
      end
      if (fl && (m_cur.size() > 0)) m_closed = 1;
    end
    if (avail && obs_in_deq) void'(src.pop_front());
  endtask

  task automatic test_reset();
    bus.in_empty_n = 1'b1;
    bus.in_data = 32'hDEAD_BEEF;
    bus.flush = 1'b0;
    bus.out_deq = 1'b1;
    #2;
    vectors++;
    if ({bus.in_deq, bus.out_valid, bus.out_count, bus.out_data, bus.batch_done} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got=%h want=0", {bus.in_deq, bus.out_valid, bus.out_count, bus.out_data, bus.batch_done});
    end
    @(negedge CLK);
    vectors++;
    if ({bus.in_deq, bus.out_valid, bus.out_count, bus.out_data, bus.batch_done} !== '0) begin
      miscompares++;
      $display("FAIL reset_held got=%h want=0", {bus.in_deq, bus.out_valid, bus.out_count, bus.out_data, bus.batch_done});
    end
    apply_reset();
  endtask

  task automatic test_basic_packing();
    apply_reset();
    src.push_back(32'h1111_1111);
    src.push_back(32'h2222_2222);
    for (int c = 0; c < 4; c++) begin
      drive(1, 0, 0);
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL basic_cycle c=%0d got=%h want=%h", c, obs_vec, exp_vec);
      end
    end
    vectors++;
    if (obs_count !== 2'd1 || obs_data !== 64'h2222_2222_1111_1111) begin
      miscompares++;
      $display("FAIL basic_beat got count=%0d data=%h want count=1 data=2222222211111111", obs_count, obs_data);
    end
  endtask

  task automatic test_batch_tail();
    logic [WW-1:0] w[BW];
    logic [AW-1:0] got[$];
    int bd_cnt, bd_src_left;
    apply_reset();
    for (int i = 0; i < BW; i++) begin
      w[i] = $urandom;
      src.push_back(w[i]);
    end
    bd_cnt = 0;
    bd_src_left = -1;
    for (int c = 0; c < 30; c++) begin
      drive(1, 0, 1);
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL batch_cycle c=%0d got=%h want=%h", c, obs_vec, exp_vec);
      end
      if (obs_valid) got.push_back(obs_data);
      if (obs_bd) begin
        bd_cnt++;
        bd_src_left = src.size();
      end
    end
    vectors++;
    if (bd_cnt != 1 || bd_src_left != 0) begin
      miscompares++;
      $display("FAIL batch_done_pulse got count=%0d src_left=%0d want count=1 src_left=0", bd_cnt, bd_src_left);
    end
    vectors++;
    if (got.size() != 5) begin
      miscompares++;
      $display("FAIL batch_beats got=%0d want=5", got.size());
    end else begin
      vectors++;
      if (got[0] !== {w[1], w[0]} || got[4] !== {32'h0, w[8]}) begin
        miscompares++;
        $display("FAIL batch_pad got first=%h last=%h want first=%h last=%h", got[0], got[4], {w[1], w[0]}, {32'h0, w[8]});
      end
    end
    src.push_back(32'hD);
    src.push_back(32'hE);
    for (int c = 0; c < 4; c++) drive(1, 0, 0);
    vectors++;
    if (obs_count !== 2'd1 || obs_data !== 64'h0000_000E_0000_000D) begin
      miscompares++;
      $display("FAIL batch_restart got count=%0d data=%h want count=1 data=0000000e0000000d", obs_count, obs_data);
    end
  endtask

  task automatic test_flush();
    apply_reset();
    src.push_back(32'h5);
    drive(1, 0, 0);
    drive(1, 1, 0);
    drive(1, 0, 0);
    drive(1, 0, 0);
    vectors++;
    if (obs_count !== 2'd1 || obs_data !== 64'h5) begin
      miscompares++;
      $display("FAIL flush_partial got count=%0d data=%h want count=1 data=5", obs_count, obs_data);
    end
    for (int c = 0; c < 3; c++) begin
      drive(1, 1, 0);
      vectors++;
      if (obs_count !== 2'd1 || obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL flush_empty c=%0d got=%h want=%h", c, obs_vec, exp_vec);
      end
    end
    src.push_back(32'h7);
    drive(1, 1, 1);
    drive(1, 0, 0);
    drive(1, 0, 0);
    vectors++;
    if (obs_count !== 2'd1 || obs_data !== 64'h7) begin
      miscompares++;
      $display("FAIL flush_same_cycle got count=%0d data=%h want count=1 data=7", obs_count, obs_data);
    end
  endtask

  task automatic test_back_pressure();
    logic [WW-1:0] w[8];
    logic [AW-1:0] got[$];
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      w[i] = $urandom;
      src.push_back(w[i]);
    end
    for (int c = 0; c < 12; c++) begin
      drive(1, 0, 0);
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL bp_cycle c=%0d got=%h want=%h", c, obs_vec, exp_vec);
      end
    end
    vectors++;
    if (obs_count !== 2'(OD) || obs_in_deq !== 1'b0 || src.size() != 2) begin
      miscompares++;
      $display("FAIL bp_stall got count=%0d in_deq=%b src_left=%0d want count=2 in_deq=0 src_left=2", obs_count, obs_in_deq, src.size());
    end
    drive(1, 0, 1);
    got.push_back(obs_data);
    drive(1, 0, 0);
    vectors++;
    if (obs_count !== 2'(OD) || obs_data !== {w[3], w[2]}) begin
      miscompares++;
      $display("FAIL full_push_pop got count=%0d head=%h want count=2 head=%h", obs_count, obs_data, {w[3], w[2]});
    end
    for (int c = 0; c < 16; c++) begin
      drive(1, 0, 1);
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL bp_drain c=%0d got=%h want=%h", c, obs_vec, exp_vec);
      end
      if (obs_valid) got.push_back(obs_data);
    end
    vectors++;
    if (got.size() != 4 || got[0] !== {w[1], w[0]} || got[1] !== {w[3], w[2]} ||
        got[2] !== {w[5], w[4]} || got[3] !== {w[7], w[6]}) begin
      miscompares++;
      $display("FAIL bp_order got n=%0d want n=4 with beats in order", got.size());
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 5; i++) src.push_back($urandom);
    for (int c = 0; c < 4; c++) drive(1, 0, 0);
    @(negedge CLK);
    #2;
    bus.in_empty_n = 1'b1;
    bus.out_deq = 1'b0;
    RST_N = 1'b0;
    #1;
    vectors++;
    if ({bus.in_deq, bus.out_valid, bus.out_count, bus.out_data, bus.batch_done} !== '0) begin
      miscompares++;
      $display("FAIL async_reset got=%h want=0", {bus.in_deq, bus.out_valid, bus.out_count, bus.out_data, bus.batch_done});
    end
    model_clear();
    bus.in_empty_n = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    src.push_back(32'hAAAA_0001);
    src.push_back(32'hAAAA_0002);
    for (int c = 0; c < 4; c++) begin
      drive(1, 0, 0);
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL post_reset_cycle c=%0d got=%h want=%h", c, obs_vec, exp_vec);
      end
    end
    vectors++;
    if (obs_count !== 2'd1 || obs_data !== 64'hAAAA_0002_AAAA_0001) begin
      miscompares++;
      $display("FAIL post_reset_beat got count=%0d data=%h want count=1 data=aaaa0002aaaa0001", obs_count, obs_data);
    end
  endtask

  task automatic test_random();
    int deq_pct;
    apply_reset();
    for (int c = 0; c < 800; c++) begin
      if (src.size() < 4) src.push_back($urandom);
      deq_pct = ((c / 100) % 2 == 1) ? 20 : 80;
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 99) < deq_pct);
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL random_cycle c=%0d got=%h want=%h", c, obs_vec, exp_vec);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    bus.in_empty_n = 1'b0;
    bus.in_data = '0;
    bus.flush = 1'b0;
    bus.out_deq = 1'b0;
    model_clear();
    test_reset();
    test_basic_packing();
    test_batch_tail();
    test_flush();
    test_back_pressure();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
